omok_game_ctrl: RTL and testbench

OMOK_GAME_CTRL -- requirements
Module: omok_game_ctrl

---
 rtl/omok_game_ctrl_pkg.sv | 32 +++
 rtl/omok_game_ctrl_if.sv | 26 ++
 rtl/omok_game_ctrl_win_probe.sv | 30 +++
 rtl/omok_game_ctrl.sv | 153 +++++++++++++++
 tb/tb_omok_game_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/omok_game_ctrl_pkg.sv
// Shared constants and encodings for the omok (gomoku) game controller.
// Board geometry, FSM states, winner codes and the four win-scan axes.
package omok_game_ctrl_pkg;

    localparam int MAP_DIM = 10;
    localparam int CELLS   = MAP_DIM * MAP_DIM;
    localparam int WIN_LEN = 5;
    localparam int MAX_PROBE = WIN_LEN - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_CHECK,
        S_UNDO,
        S_OVER
    } state_e;

    localparam logic [1:0] W_NONE  = 2'b00;
    localparam logic [1:0] W_BLACK = 2'b01;
    localparam logic [1:0] W_WHITE = 2'b10;
    localparam logic [1:0] W_DRAW  = 2'b11;

    // Axis order is the scan order: horizontal, vertical, down-right, down-left.
    // Index step on the + side, plus the column delta used for edge detection.
    localparam logic [1:0] AX_H  = 2'd0;
    localparam logic [1:0] AX_V  = 2'd1;
    localparam logic [1:0] AX_DR = 2'd2;
    localparam logic [1:0] AX_DL = 2'd3;
    localparam int AX_STEP [4] = '{1, MAP_DIM, MAP_DIM + 1, MAP_DIM - 1};
    localparam int AX_DC   [4] = '{1, 0, 1, -1};

endpackage

// File: rtl/omok_game_ctrl_if.sv
// Button inputs and board/status outputs of the game controller.
// master drives buttons and observes; slave is the controller itself.
interface omok_game_ctrl_if #(parameter int MAP_DIM = omok_game_ctrl_pkg::MAP_DIM);

    localparam int NCELL = MAP_DIM * MAP_DIM;

    logic             left, right, up, down, put, undo;
    logic [NCELL-1:0] board_state;
    logic [NCELL-1:0] turn_map;
    logic [7:0]       cursor_pos;
    logic             turn;
    logic [1:0]       winner;
    logic             game_over;
    logic             busy;

    modport master (
        output left, right, up, down, put, undo,
        input  board_state, turn_map, cursor_pos, turn, winner, game_over, busy
    );

    modport slave (
        input  left, right, up, down, put, undo,
        output board_state, turn_map, cursor_pos, turn, winner, game_over, busy
    );

endinterface

// File: rtl/omok_game_ctrl_win_probe.sv
// Neighbour address for one win-scan probe: step cells from pos along an axis,
// on the + or - side, flagged invalid when the walk leaves the board.
module omok_win_probe #(
    parameter int MAP_DIM = omok_game_ctrl_pkg::MAP_DIM,
    parameter int IW      = 7
) (
    input  logic [IW-1:0] pos_i,
    input  logic [1:0]    axis_i,
    input  logic          side_i,
    input  logic [2:0]    step_i,
    output logic [IW-1:0] next_o,
    output logic          valid_o
);
    import omok_game_ctrl_pkg::*;

    int sgn, row, col, r, c, n;

    always_comb begin
        sgn     = side_i ? -1 : 1;
        row     = int'(pos_i) / MAP_DIM;
        col     = int'(pos_i) % MAP_DIM;
        r       = row + ((axis_i == AX_H) ? 0 : sgn * int'(step_i));
        c       = col + sgn * int'(step_i) * AX_DC[axis_i];
        n       = int'(pos_i) + sgn * int'(step_i) * AX_STEP[axis_i];
        // Row/col bounds catch wrap-around that the flat index alone would miss.
        valid_o = (r >= 0) && (r < MAP_DIM) && (c >= 0) && (c < MAP_DIM);
        next_o  = valid_o ? IW'(n) : '0;
    end

endmodule

// File: rtl/omok_game_ctrl.sv
// Omok game controller: cursor, stone placement, undo history and a
// one-probe-per-cycle five-in-a-row check around the last placed stone.
module omok_game_ctrl #(
    parameter int MAP_DIM = omok_game_ctrl_pkg::MAP_DIM
) (
    input  logic              clk,
    input  logic              rst,
    omok_game_ctrl_if.slave   bus
);
    import omok_game_ctrl_pkg::*;

    localparam int NCELL  = MAP_DIM * MAP_DIM;
    localparam int IW     = $clog2(NCELL);
    localparam int CENTER = (MAP_DIM / 2 - 1) * MAP_DIM + (MAP_DIM / 2 - 1);

    // Button bit order doubles as event priority, highest first.
    localparam int EV_UNDO = 5, EV_PUT = 4, EV_RIGHT = 3, EV_LEFT = 2, EV_UP = 1, EV_DOWN = 0;

    state_e           state_q;
    logic [NCELL-1:0] board_q, white_q;
    logic [IW-1:0]    cursor_q, last_q, mcnt_q;
    logic             turn_q;
    logic [1:0]       winner_q;
    logic [5:0]       btn_q;
    logic [1:0]       axis_q;
    logic             side_q;
    logic [2:0]       step_q;
    logic [3:0]       cnt_q;
    logic [IW-1:0]    hist_q [NCELL];

    logic [5:0]       btn_d, ev_d;
    logic [IW-1:0]    probe_pos, pop_pos;
    logic             probe_ok, hit_d, side_end_d;
    logic [3:0]       cnt_d;
    int               cur_row, cur_col;

    assign btn_d   = {bus.undo, bus.put, bus.right, bus.left, bus.up, bus.down};
    assign ev_d    = btn_d & ~btn_q;
    assign cur_row = int'(cursor_q) / MAP_DIM;
    assign cur_col = int'(cursor_q) % MAP_DIM;
    assign pop_pos = hist_q[mcnt_q - IW'(1)];

    omok_win_probe #(.MAP_DIM(MAP_DIM), .IW(IW)) u_probe (
        .pos_i   (last_q),
        .axis_i  (axis_q),
        .side_i  (side_q),
        .step_i  (step_q),
        .next_o  (probe_pos),
        .valid_o (probe_ok)
    );

    assign hit_d      = probe_ok && board_q[probe_pos] && (white_q[probe_pos] == turn_q);
    assign cnt_d      = cnt_q + {3'b000, hit_d};
    assign side_end_d = !hit_d || (step_q == 3'(MAX_PROBE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            white_q  <= '0;
            cursor_q <= IW'(CENTER);
            last_q   <= '0;
            mcnt_q   <= '0;
            turn_q   <= 1'b0;
            winner_q <= W_NONE;
            btn_q    <= '0;
            axis_q   <= AX_H;
            side_q   <= 1'b0;
            step_q   <= 3'd1;
            cnt_q    <= '0;
        end else begin
            btn_q <= btn_d;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (ev_d[EV_UNDO]) begin
                        if (mcnt_q != '0) begin
                            state_q <= S_UNDO;
                            // A finished game never toggled the mover, so only IDLE undo flips.
                            if (state_q == S_IDLE) turn_q <= ~turn_q;
                        end
                    end else if (ev_d[EV_PUT]) begin
                        if (state_q == S_IDLE && !board_q[cursor_q]) state_q <= S_PLACE;
                    end else if (ev_d[EV_RIGHT]) begin
                        if (cur_col != MAP_DIM - 1) cursor_q <= cursor_q + IW'(1);
                    end else if (ev_d[EV_LEFT]) begin
                        if (cur_col != 0) cursor_q <= cursor_q - IW'(1);
                    end else if (ev_d[EV_UP]) begin
                        if (cur_row != 0) cursor_q <= cursor_q - IW'(MAP_DIM);
                    end else if (ev_d[EV_DOWN]) begin
                        if (cur_row != MAP_DIM - 1) cursor_q <= cursor_q + IW'(MAP_DIM);
                    end
                end
                S_PLACE: begin
                    board_q[cursor_q] <= 1'b1;
                    white_q[cursor_q] <= turn_q;
                    mcnt_q            <= mcnt_q + IW'(1);
                    last_q            <= cursor_q;
                    axis_q            <= AX_H;
                    side_q            <= 1'b0;
                    step_q            <= 3'd1;
                    cnt_q             <= '0;
                    state_q           <= S_CHECK;
                end
                S_CHECK: begin
                    if (!side_end_d) begin
                        step_q <= step_q + 3'd1;
                        cnt_q  <= cnt_d;
                    end else if (!side_q) begin
                        side_q <= 1'b1;
                        step_q <= 3'd1;
                        cnt_q  <= cnt_d;
                    end else if (cnt_d >= 4'(WIN_LEN - 1)) begin
                        winner_q <= turn_q ? W_WHITE : W_BLACK;
                        state_q  <= S_OVER;
                    end else if (axis_q != AX_DL) begin
                        axis_q <= axis_q + 2'd1;
                        side_q <= 1'b0;
                        step_q <= 3'd1;
                        cnt_q  <= '0;
                    end else if (mcnt_q == IW'(NCELL)) begin
                        winner_q <= W_DRAW;
                        state_q  <= S_OVER;
                    end else begin
                        turn_q  <= ~turn_q;
                        state_q <= S_IDLE;
                    end
                end
                S_UNDO: begin
                    board_q[pop_pos] <= 1'b0;
                    white_q[pop_pos] <= 1'b0;
                    mcnt_q           <= mcnt_q - IW'(1);
                    winner_q         <= W_NONE;
                    state_q          <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Entries at or above move_count are never read, so the stack needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_PLACE) hist_q[mcnt_q] <= cursor_q;
    end

    assign bus.board_state = board_q;
    assign bus.turn_map    = white_q;
    assign bus.cursor_pos  = 8'(cursor_q);
    assign bus.turn        = turn_q;
    assign bus.winner      = winner_q;
    assign bus.game_over   = (winner_q != W_NONE);
    assign bus.busy        = (state_q == S_PLACE) || (state_q == S_CHECK) || (state_q == S_UNDO);

endmodule

// File: tb/tb_omok_game_ctrl.sv
// Scoreboard bench for omok_game_ctrl: expectations are queued as each
// stimulus is driven and compared once the controller has settled.
module tb_omok_game_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    omok_game_ctrl_if #(.MAP_DIM(10)) bus();
    omok_game_ctrl #(.MAP_DIM(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [5:0] B_DOWN = 6'd1, B_UP = 6'd2, B_LEFT = 6'd4, B_RIGHT = 6'd8,
                           B_PUT = 6'd16, B_UNDO = 6'd32;
    localparam int K_CUR = 0, K_TURN = 1, K_WIN = 2, K_OVER = 3, K_BUSY = 4,
                   K_BRD = 5, K_WHT = 6, K_CNT = 7, K_WCNT = 8;

    typedef struct {
        string tag;
        int    kind;
        int    arg;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, expv);
        end
    endtask

    function automatic logic [31:0] obs(input int kind, input int arg);
        case (kind)
            K_CUR:   return 32'(bus.cursor_pos);
            K_TURN:  return 32'(bus.turn);
            K_WIN:   return 32'(bus.winner);
            K_OVER:  return 32'(bus.game_over);
            K_BUSY:  return 32'(bus.busy);
            K_BRD:   return 32'(bus.board_state[arg]);
            K_WHT:   return 32'(bus.turn_map[arg]);
            K_CNT:   return 32'($countones(bus.board_state));
            default: return 32'($countones(bus.turn_map));
        endcase
    endfunction

    task automatic expect_q(input string tag, input int kind, input int arg, input int val);
        exp_t e;
        e.tag = tag; e.kind = kind; e.arg = arg; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.kind, e.arg), 32'(e.val));
        end
    endtask

    task automatic settle();
        int n = 0;
        while (bus.busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("settle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic set_btn(input logic [5:0] m);
        {bus.undo, bus.put, bus.right, bus.left, bus.up, bus.down} = m;
    endtask

    task automatic press(input logic [5:0] m);
        @(negedge clk);
        set_btn(m);
        @(negedge clk);
        set_btn(6'd0);
        settle();
    endtask

    task automatic goto_cell(input int t);
        int r, c;
        for (int i = 0; i < 40 && int'(bus.cursor_pos) != t; i++) begin
            r = int'(bus.cursor_pos) / 10;
            c = int'(bus.cursor_pos) % 10;
            if (c < t % 10)      press(B_RIGHT);
            else if (c > t % 10) press(B_LEFT);
            else if (r < t / 10) press(B_DOWN);
            else                 press(B_UP);
        end
    endtask

    task automatic place(input int t);
        goto_cell(t);
        press(B_PUT);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_reset(input string pfx);
        expect_q({pfx, "_cur"},  K_CUR,  0, 44);
        expect_q({pfx, "_turn"}, K_TURN, 0, 0);
        expect_q({pfx, "_win"},  K_WIN,  0, 0);
        expect_q({pfx, "_over"}, K_OVER, 0, 0);
        expect_q({pfx, "_busy"}, K_BUSY, 0, 0);
        expect_q({pfx, "_brd"},  K_CNT,  0, 0);
        expect_q({pfx, "_wht"},  K_WCNT, 0, 0);
    endtask

    initial begin
        int lat;
        int bl[$], wl[$];
        set_btn(6'd0);

        // Reset values while rst is held
        repeat (2) @(negedge clk);
        expect_reset("rst");
        drain();
        rst = 1'b0;

        // Cursor walk and right-edge block
        repeat (3) press(B_RIGHT);
        repeat (2) press(B_DOWN);
        expect_q("cur67", K_CUR, 0, 67);
        drain();
        repeat (2) press(B_RIGHT);
        press(B_RIGHT);
        expect_q("cur_edge", K_CUR, 0, 69);
        drain();

        // Black row 40..44 against white 50..53
        do_reset();
        place(40);
        expect_q("b40_brd", K_BRD, 40, 1);
        expect_q("b40_wht", K_WHT, 40, 0);
        expect_q("b40_turn", K_TURN, 0, 1);
        drain();
        press(B_PUT);
        expect_q("occ_cnt", K_CNT, 0, 1);
        expect_q("occ_turn", K_TURN, 0, 1);
        drain();
        goto_cell(50);
        press(B_PUT | B_RIGHT);
        expect_q("pr_brd", K_BRD, 50, 1);
        expect_q("pr_wht", K_WHT, 50, 1);
        expect_q("pr_cur", K_CUR, 0, 50);
        expect_q("pr_turn", K_TURN, 0, 0);
        drain();
        place(41); place(51); place(42); place(52); place(43); place(53);
        goto_cell(44);
        @(negedge clk);
        set_btn(B_PUT);
        @(negedge clk);
        set_btn(6'd0);
        lat = 0;
        while (!bus.game_over && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("win_latency_le34", 32'(lat <= 34), 32'd1);
        expect_q("bwin_win", K_WIN, 0, 1);
        expect_q("bwin_over", K_OVER, 0, 1);
        expect_q("bwin_turn", K_TURN, 0, 0);
        expect_q("bwin_cnt", K_CNT, 0, 9);
        drain();

        // Undo out of OVER keeps turn, undo from IDLE toggles it
        press(B_UNDO);
        expect_q("u1_brd44", K_BRD, 44, 0);
        expect_q("u1_win", K_WIN, 0, 0);
        expect_q("u1_over", K_OVER, 0, 0);
        expect_q("u1_turn", K_TURN, 0, 0);
        expect_q("u1_cnt", K_CNT, 0, 8);
        drain();
        press(B_UNDO);
        expect_q("u2_brd53", K_BRD, 53, 0);
        expect_q("u2_wht53", K_WHT, 53, 0);
        expect_q("u2_turn", K_TURN, 0, 1);
        expect_q("u2_cnt", K_CNT, 0, 7);
        drain();

        // White down-right diagonal 0,11,22,33,44
        do_reset();
        place(90); place(0); place(92); place(11); place(94);
        place(22); place(96); place(33); place(98); place(44);
        expect_q("wwin_win", K_WIN, 0, 2);
        expect_q("wwin_over", K_OVER, 0, 1);
        expect_q("wwin_wht44", K_WHT, 44, 1);
        expect_q("wwin_turn", K_TURN, 0, 1);
        drain();
        place(45);
        expect_q("over_put_brd", K_BRD, 45, 0);
        expect_q("over_put_cnt", K_CNT, 0, 10);
        expect_q("over_put_win", K_WIN, 0, 2);
        expect_q("over_put_cur", K_CUR, 0, 45);
        drain();

        // Undo with empty history
        do_reset();
        press(B_UNDO);
        expect_q("u0_cnt", K_CNT, 0, 0);
        expect_q("u0_turn", K_TURN, 0, 0);
        expect_q("u0_busy", K_BUSY, 0, 0);
        expect_q("u0_win", K_WIN, 0, 0);
        drain();

        // Reset pulse in the middle of CHECK
        goto_cell(33);
        @(negedge clk);
        set_btn(B_PUT);
        @(negedge clk);
        set_btn(6'd0);
        @(negedge clk);
        expect_q("chk_busy", K_BUSY, 0, 1);
        drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_reset("midchk");
        drain();
        @(negedge clk);
        rst = 1'b0;

        // Full board with no five-in-a-row ends in a draw
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                if (((c / 2) + r) % 2 == 0) bl.push_back(r * 10 + c);
                else                        wl.push_back(r * 10 + c);
        for (int i = 0; i < 50; i++) begin
            place(bl[i]);
            place(wl[i]);
        end
        expect_q("draw_win", K_WIN, 0, 3);
        expect_q("draw_over", K_OVER, 0, 1);
        expect_q("draw_cnt", K_CNT, 0, 100);
        expect_q("draw_wcnt", K_WCNT, 0, 50);
        expect_q("draw_turn", K_TURN, 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
